mult_seq_param: RTL

//  Parametrised iterative A_W x B_W multiplier; successor to the fixed 32x32 fast multiplier.

---
 rtl/mult_seq_param.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mult_seq_param.sv
// Iterative A_W x B_W multiplier: one DA x DB digit partial product per cycle, signed/unsigned per operation.
// Optional early termination of all-zero high digits is enabled by defining MULT_EARLY_TERM_EN.
module mult_seq_param #(
  parameter int A_W = 32,
  parameter int B_W = 32,
  parameter int DA  = 16,
  parameter int DB  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int NA   = A_W / DA;
  localparam int NB   = B_W / DB;
  localparam int P_W  = A_W + B_W;
  localparam int IA_W = (NA > 1) ? $clog2(NA) : 1;
  localparam int IB_W = (NB > 1) ? $clog2(NB) : 1;

  if (A_W % DA != 0) begin : g_bad_da
    $error("mult_seq_param: A_W must be a multiple of DA");
  end
  if (B_W % DB != 0) begin : g_bad_db
    $error("mult_seq_param: B_W must be a multiple of DB");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

  state_t           r_state;
  logic [A_W-1:0]   r_a_mag;
  logic [B_W-1:0]   r_b_mag;
  logic             r_neg;
  logic [P_W-1:0]   r_acc;
  logic [IA_W-1:0]  r_i;
  logic [IA_W-1:0]  r_la;
  logic [IB_W-1:0]  r_j;
  logic [IB_W-1:0]  r_lb;
  logic             r_busy;
  logic             r_done;
  logic [P_W-1:0]   r_product;

  logic [A_W-1:0]   w_a_mag;
  logic [B_W-1:0]   w_b_mag;
  logic [IA_W-1:0]  w_la;
  logic [IB_W-1:0]  w_lb;
  logic [DA-1:0]    w_a_dig;
  logic [DB-1:0]    w_b_dig;
  logic [DA+DB-1:0] w_pp;
  logic [P_W-1:0]   w_term;

  // Operand magnitudes; the most-negative value maps to 2^(W-1), which still fits unsigned.
  assign w_a_mag = (signed_op && a[A_W-1]) ? -a : a;
  assign w_b_mag = (signed_op && b[B_W-1]) ? -b : b;

  always_comb begin
    w_la = '0;
    w_lb = '0;
`ifdef MULT_EARLY_TERM_EN
    for (int k = 0; k < NA; k++)
      if (DA'(w_a_mag >> (k * DA)) != '0) w_la = IA_W'(k);
    for (int k = 0; k < NB; k++)
      if (DB'(w_b_mag >> (k * DB)) != '0) w_lb = IB_W'(k);
`else
    w_la = IA_W'(NA - 1);
    w_lb = IB_W'(NB - 1);
`endif
  end

  assign w_a_dig = DA'(r_a_mag >> (int'(r_i) * DA));
  assign w_b_dig = DB'(r_b_mag >> (int'(r_j) * DB));
  assign w_pp    = (DA+DB)'(w_a_dig) * (DA+DB)'(w_b_dig);
  assign w_term  = P_W'(w_pp) << (int'(r_i) * DA + int'(r_j) * DB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_la      <= '0;
      r_lb      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_mag <= w_a_mag;
            r_b_mag <= w_b_mag;
            r_neg   <= signed_op & (a[A_W-1] ^ b[B_W-1]);
            r_la    <= w_la;
            r_lb    <= w_lb;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        // j walks the b-digits inside each a-digit
        S_CALC: begin
          r_acc <= r_acc + w_term;
          if (r_j == r_lb) begin
            r_j <= '0;
            if (r_i == r_la) r_state <= S_FINISH;
            else             r_i     <= r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_FINISH: begin
          r_product <= r_neg ? -r_acc : r_acc;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
